pipe_stage_fifo: RTL and testbench

- Parametrised successor to the single-register pipeline stage buffer.
- Stores WIDTH-bit flat packets in a DEPTH-entry elastic FIFO with valid/ready handshakes on both sides.
- On each push, merges the new-stage packet into the previous-buffer packet under a parameter-selected bit mask, or writes an invalidated bubble.
- Sits between CPU pipeline stages so a downstream stall no longer forces an immediate upstream stall.

---
 rtl/pipe_stage_fifo.sv | 120 ++++++++++++
 tb/tb_pipe_stage_fifo.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_fifo.sv
// Elastic pipeline-stage buffer: merges the previous-buffer and new-stage packets
// under a selectable mask (or writes a bubble) and queues the result in a small FIFO.
module pipe_stage_fifo #(
  parameter int                         WIDTH       = 64,
  parameter int                         DEPTH       = 2,
  parameter int                         NUM_SEL     = 4,
  parameter logic [NUM_SEL*WIDTH-1:0]   MERGE_MASKS = '0,
  parameter logic [WIDTH-1:0]           KEEP_MASK   = '0,
  parameter int                         VALID_BIT   = 0,
  localparam int                        SEL_W       = $clog2(NUM_SEL + 1),
  localparam int                        CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [SEL_W-1:0]  i_sel,
  input  logic [WIDTH-1:0]  i_pkt_old,
  input  logic [WIDTH-1:0]  i_pkt_new,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [WIDTH-1:0]  o_pkt_out,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_err_sel
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_err_sel;

  logic [WIDTH-1:0] w_masks [NUM_SEL];
  logic [WIDTH-1:0] w_mem   [DEPTH];
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_bubble;
  logic [WIDTH-1:0] w_entry;
  logic             w_legal;
  logic             w_illegal;
  logic             w_push;
  logic             w_pop;
  logic             w_wr_en;

  genvar gi;

  generate
    for (gi = 0; gi < NUM_SEL; gi++) begin : g_mask
      assign w_masks[gi] = MERGE_MASKS[gi*WIDTH +: WIDTH];
    end
  endgenerate

  always_comb begin
    w_mask    = '0;
    w_legal   = (i_sel < SEL_W'(NUM_SEL));
    w_illegal = (i_sel > SEL_W'(NUM_SEL));
    for (int i = 0; i < NUM_SEL; i++) begin
      if (i_sel == SEL_W'(i)) w_mask = w_masks[i];
    end
    w_bubble            = i_pkt_old & KEEP_MASK;
    w_bubble[VALID_BIT] = 1'b0;
    // Illegal selects fall through to the bubble path.
    w_entry = w_legal ? ((i_pkt_old & ~w_mask) | (i_pkt_new & w_mask)) : w_bubble;
  end

  // in_ready depends only on registered occupancy and the reset pin.
  assign o_in_ready  = i_rst_n & (r_count < CNT_W'(DEPTH));
  assign o_out_valid = (r_count != '0);
  assign w_push      = i_in_valid & o_in_ready;
  assign w_pop       = o_out_valid & i_out_ready;
  assign w_wr_en     = w_push & ~i_flush;

  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] r_entry;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_entry <= '0;
        end else if (w_wr_en && (r_wr_ptr == PTR_W'(gi))) begin
          r_entry <= w_entry;
        end
      end
      assign w_mem[gi] = r_entry;
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err_sel <= 1'b0;
    end else if (w_wr_en && w_illegal) begin
      r_err_sel <= 1'b1;
    end
  end

  assign o_pkt_out = o_out_valid ? w_mem[r_rd_ptr] : '0;
  assign o_count   = r_count;
  assign o_err_sel = r_err_sel;

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Directed bench for pipe_stage_fifo: merge, bubble, backpressure, wrap, flush,
// illegal select and asynchronous reset.
module tb_pipe_stage_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  sel;
  logic [15:0] pkt_old;
  logic [15:0] pkt_new;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] pkt_out;
  logic [2:0]  count;
  logic        err_sel;

  // Second instance with NUM_SEL=4 so a 3-bit select can carry illegal codes.
  logic        in_valid2;
  logic        in_ready2;
  logic [2:0]  sel2;
  logic        out_valid2;
  logic        out_ready2;
  logic [15:0] pkt_out2;
  logic [1:0]  count2;
  logic        err_sel2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_stage_fifo #(
    .WIDTH(16), .DEPTH(4), .NUM_SEL(3),
    .MERGE_MASKS(48'hFF00_00FF_0000), .KEEP_MASK(16'h00F0), .VALID_BIT(15)
  ) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_sel(sel),
    .i_pkt_old(pkt_old), .i_pkt_new(pkt_new),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_pkt_out(pkt_out), .o_count(count), .o_err_sel(err_sel)
  );

  pipe_stage_fifo #(
    .WIDTH(16), .DEPTH(2), .NUM_SEL(4),
    .MERGE_MASKS(64'hF0F0_FF00_00FF_0000), .KEEP_MASK(16'h00F0), .VALID_BIT(15)
  ) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_in_valid(in_valid2), .o_in_ready(in_ready2), .i_sel(sel2),
    .i_pkt_old(pkt_old), .i_pkt_new(pkt_new),
    .o_out_valid(out_valid2), .i_out_ready(out_ready2),
    .o_pkt_out(pkt_out2), .o_count(count2), .o_err_sel(err_sel2)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; sel = 2'd0;
    pkt_old = 16'h0; pkt_new = 16'h0; out_ready = 1'b0;
    in_valid2 = 1'b0; sel2 = 3'd0; out_ready2 = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 16'(count), 16'd0);
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_pkt_out", pkt_out, 16'h0000);
    check("rst_in_ready", 16'(in_ready), 16'd0);
    check("rst_err_sel", 16'(err_sel), 16'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 16'(in_ready), 16'd1);

    // 1. Merge
    pkt_old = 16'h1234; pkt_new = 16'hABCD; in_valid = 1'b1;
    sel = 2'd1; step();
    check("merge1_count", 16'(count), 16'd1);
    check("merge1_valid", 16'(out_valid), 16'd1);
    check("merge1_pkt", pkt_out, 16'h12CD);
    sel = 2'd2; step();
    sel = 2'd0; step();
    in_valid = 1'b0;
    check("merge_count3", 16'(count), 16'd3);
    check("merge_head_hold", pkt_out, 16'h12CD);
    out_ready = 1'b1; step();
    check("merge2_pkt", pkt_out, 16'hAB34);
    step();
    check("merge0_pkt", pkt_out, 16'h1234);
    step();
    out_ready = 1'b0;
    check("merge_empty_count", 16'(count), 16'd0);
    check("merge_empty_valid", 16'(out_valid), 16'd0);
    check("merge_empty_pkt", pkt_out, 16'h0000);

    // 2. Invalidate
    pkt_old = 16'h9AF3; sel = 2'd3; in_valid = 1'b1; step();
    in_valid = 1'b0;
    check("inval_pkt", pkt_out, 16'h00F0);
    check("inval_err", 16'(err_sel), 16'd0);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    check("inval_drain", 16'(count), 16'd0);

    // 3. Full / backpressure
    pkt_old = 16'h0; sel = 2'd1; in_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      pkt_new = 16'(k); step();
      check("fill_count", 16'(count), 16'(k));
    end
    check("full_in_ready", 16'(in_ready), 16'd0);
    pkt_new = 16'h0005; step();
    check("full_no_push", 16'(count), 16'd4);
    check("full_head", pkt_out, 16'h0001);
    out_ready = 1'b1; step();
    check("full_pop_only", 16'(count), 16'd3);
    check("full_pop_head", pkt_out, 16'h0002);
    out_ready = 1'b0; step();
    check("refill_count", 16'(count), 16'd4);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      check("full_drain_pkt", pkt_out, 16'(k));
      step();
    end
    out_ready = 1'b0;
    check("full_drained", 16'(count), 16'd0);

    // 4. Simultaneous push/pop across pointer wrap
    in_valid = 1'b1;
    pkt_new = 16'h0010; step();
    pkt_new = 16'h0011; step();
    check("pp_setup_count", 16'(count), 16'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pkt_new = 16'(16'h12 + i);
      check("pp_head", pkt_out, 16'(16'h10 + i));
      step();
      check("pp_count", 16'(count), 16'd2);
    end
    in_valid = 1'b0;
    check("pp_tail0", pkt_out, 16'h001A);
    step();
    check("pp_tail1", pkt_out, 16'h001B);
    step();
    out_ready = 1'b0;
    check("pp_empty", 16'(count), 16'd0);

    // 5. Flush with concurrent push
    in_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      pkt_new = 16'(16'h20 + k); step();
    end
    check("flush_pre_count", 16'(count), 16'd3);
    flush = 1'b1; pkt_new = 16'h0024; step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_count", 16'(count), 16'd0);
    check("flush_valid", 16'(out_valid), 16'd0);
    check("flush_pkt", pkt_out, 16'h0000);
    in_valid = 1'b1; pkt_new = 16'h0030; step();
    in_valid = 1'b0;
    check("post_flush_count", 16'(count), 16'd1);
    check("post_flush_pkt", pkt_out, 16'h0030);

    // 6. Illegal select, then asynchronous reset
    sel2 = 3'd6; step();
    check("illegal_nopush_err", 16'(err_sel2), 16'd0);
    pkt_old = 16'h9AF3; sel2 = 3'd5; in_valid2 = 1'b1; step();
    in_valid2 = 1'b0;
    check("illegal_err", 16'(err_sel2), 16'd1);
    check("illegal_pkt", pkt_out2, 16'h00F0);
    check("illegal_count", 16'(count2), 16'd1);
    check("main_err_clear", 16'(err_sel), 16'd0);
    step();
    check("err_sticky", 16'(err_sel2), 16'd1);
    #3 rst_n = 1'b0;
    #1;
    check("async_count", 16'(count), 16'd0);
    check("async_valid", 16'(out_valid), 16'd0);
    check("async_pkt", pkt_out, 16'h0000);
    check("async_in_ready", 16'(in_ready), 16'd0);
    check("async_err2", 16'(err_sel2), 16'd0);
    check("async_pkt2", pkt_out2, 16'h0000);
    check("async_count2", 16'(count2), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
